// File: rtl/pixel_write_scheduler.sv
// Pixel write scheduler: round-robin arbiter for two players' pixel writes onto
// one VGA write port, plus a row-major full-screen clear sweep.
module pixel_write_scheduler #(
    parameter int         X_MAX        = 159,
    parameter int         Y_MAX        = 119,
    parameter logic [2:0] CLEAR_COLOUR = 3'b000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       clear_req,
    input  logic       p1_req,
    input  logic [7:0] p1_x,
    input  logic [6:0] p1_y,
    input  logic [2:0] p1_colour,
    input  logic       p2_req,
    input  logic [7:0] p2_x,
    input  logic [6:0] p2_y,
    input  logic [2:0] p2_colour,
    output logic       p1_gnt,
    output logic       p2_gnt,
    output logic [7:0] x,
    output logic [6:0] y,
    output logic [2:0] colour,
    output logic       plot,
    output logic       busy,
    output logic       clear_done,
    output logic       coord_err
);

    localparam logic [7:0] X_LAST = 8'(X_MAX);
    localparam logic [6:0] Y_LAST = 7'(Y_MAX);

    typedef enum logic {IDLE, CLEAR} state_t;

    state_t     state_q, state_d;
    logic [7:0] x_q, x_d;
    logic [6:0] y_q, y_d;
    logic [2:0] colour_q, colour_d;
    logic       plot_q, plot_d;
    logic       p1_gnt_q, p1_gnt_d;
    logic       p2_gnt_q, p2_gnt_d;
    logic       busy_q, busy_d;
    logic       clear_done_q, clear_done_d;
    logic       coord_err_q, coord_err_d;
    logic [7:0] sweep_x_q, sweep_x_d;
    logic [6:0] sweep_y_q, sweep_y_d;
    logic       favour_p2_q, favour_p2_d;

    logic       p1_live, p2_live, p1_wins, in_range, sweep_last;
    logic [7:0] win_x;
    logic [6:0] win_y;
    logic [2:0] win_colour;

    // A requester granted this cycle is masked so its still-held req cannot repeat the write.
    assign p1_live    = p1_req & ~p1_gnt_q;
    assign p2_live    = p2_req & ~p2_gnt_q;
    assign p1_wins    = p1_live & (~p2_live | ~favour_p2_q);
    assign win_x      = p1_wins ? p1_x : p2_x;
    assign win_y      = p1_wins ? p1_y : p2_y;
    assign win_colour = p1_wins ? p1_colour : p2_colour;
    assign in_range   = (win_x <= X_LAST) && (win_y <= Y_LAST);
    assign sweep_last = (sweep_x_q == X_LAST) && (sweep_y_q == Y_LAST);

    always_comb begin
        state_d      = state_q;
        x_d          = x_q;
        y_d          = y_q;
        colour_d     = colour_q;
        plot_d       = 1'b0;
        p1_gnt_d     = 1'b0;
        p2_gnt_d     = 1'b0;
        busy_d       = 1'b0;
        clear_done_d = 1'b0;
        coord_err_d  = 1'b0;
        sweep_x_d    = sweep_x_q;
        sweep_y_d    = sweep_y_q;
        favour_p2_d  = favour_p2_q;

        case (state_q)
            IDLE: begin
                if (clear_req) begin
                    state_d   = CLEAR;
                    sweep_x_d = '0;
                    sweep_y_d = '0;
                    x_d       = '0;
                    y_d       = '0;
                    colour_d  = CLEAR_COLOUR;
                    plot_d    = 1'b1;
                    busy_d    = 1'b1;
                end else if (p1_live || p2_live) begin
                    p1_gnt_d    = p1_wins;
                    p2_gnt_d    = ~p1_wins;
                    favour_p2_d = p1_wins;
                    if (in_range) begin
                        x_d      = win_x;
                        y_d      = win_y;
                        colour_d = win_colour;
                        plot_d   = 1'b1;
                    end else begin
                        coord_err_d = 1'b1;
                    end
                end
            end
            CLEAR: begin
                // The sweep counters hold the pixel on the port this cycle.
                if (sweep_last) begin
                    state_d      = IDLE;
                    clear_done_d = 1'b1;
                    sweep_x_d    = '0;
                    sweep_y_d    = '0;
                end else begin
                    if (sweep_x_q == X_LAST) begin
                        sweep_x_d = '0;
                        sweep_y_d = sweep_y_q + 7'd1;
                    end else begin
                        sweep_x_d = sweep_x_q + 8'd1;
                    end
                    x_d      = sweep_x_d;
                    y_d      = sweep_y_d;
                    colour_d = CLEAR_COLOUR;
                    plot_d   = 1'b1;
                    busy_d   = 1'b1;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q      <= IDLE;
            x_q          <= '0;
            y_q          <= '0;
            colour_q     <= '0;
            plot_q       <= 1'b0;
            p1_gnt_q     <= 1'b0;
            p2_gnt_q     <= 1'b0;
            busy_q       <= 1'b0;
            clear_done_q <= 1'b0;
            coord_err_q  <= 1'b0;
            sweep_x_q    <= '0;
            sweep_y_q    <= '0;
            favour_p2_q  <= 1'b0;
        end else begin
            state_q      <= state_d;
            x_q          <= x_d;
            y_q          <= y_d;
            colour_q     <= colour_d;
            plot_q       <= plot_d;
            p1_gnt_q     <= p1_gnt_d;
            p2_gnt_q     <= p2_gnt_d;
            busy_q       <= busy_d;
            clear_done_q <= clear_done_d;
            coord_err_q  <= coord_err_d;
            sweep_x_q    <= sweep_x_d;
            sweep_y_q    <= sweep_y_d;
            favour_p2_q  <= favour_p2_d;
        end
    end

    assign x          = x_q;
    assign y          = y_q;
    assign colour     = colour_q;
    assign plot       = plot_q;
    assign p1_gnt     = p1_gnt_q;
    assign p2_gnt     = p2_gnt_q;
    assign busy       = busy_q;
    assign clear_done = clear_done_q;
    assign coord_err  = coord_err_q;

endmodule

// File: tb/tb_pixel_write_scheduler.sv
// Bench for pixel_write_scheduler: a behavioural model predicts every write, grant
// and status pulse into a queue that a monitor drains against the DUT outputs.
module tb_pixel_write_scheduler;

    localparam int         XM   = 159;
    localparam int         YM   = 119;
    localparam int         NPIX = (XM + 1) * (YM + 1);
    localparam logic [2:0] CC   = 3'b000;

    logic       clk       = 1'b0;
    logic       reset     = 1'b1;
    logic       clear_req = 1'b0;
    logic       p1_req    = 1'b0;
    logic [7:0] p1_x      = '0;
    logic [6:0] p1_y      = '0;
    logic [2:0] p1_colour = '0;
    logic       p2_req    = 1'b0;
    logic [7:0] p2_x      = '0;
    logic [6:0] p2_y      = '0;
    logic [2:0] p2_colour = '0;
    logic       p1_gnt, p2_gnt, plot, busy, clear_done, coord_err;
    logic [7:0] x;
    logic [6:0] y;
    logic [2:0] colour;

    pixel_write_scheduler #(.X_MAX(XM), .Y_MAX(YM), .CLEAR_COLOUR(CC)) dut (
        .clk(clk), .reset(reset), .clear_req(clear_req),
        .p1_req(p1_req), .p1_x(p1_x), .p1_y(p1_y), .p1_colour(p1_colour),
        .p2_req(p2_req), .p2_x(p2_x), .p2_y(p2_y), .p2_colour(p2_colour),
        .p1_gnt(p1_gnt), .p2_gnt(p2_gnt), .x(x), .y(y), .colour(colour),
        .plot(plot), .busy(busy), .clear_done(clear_done), .coord_err(coord_err)
    );

    always #5 clk = ~clk;

    typedef struct {
        int          stamp;
        bit          chk;
        logic [23:0] vec;
    } ev_t;

    ev_t exp_q[$];
    int  cyc    = 0;
    int  checks = 0;
    int  passed = 0;
    int  m1     = 0;
    int  m2     = 0;

    function automatic logic [23:0] pack(input logic g1, input logic g2, input logic pl,
                                         input logic bz, input logic dn, input logic er,
                                         input logic [7:0] px, input logic [6:0] py,
                                         input logic [2:0] pc);
        return {g1, g2, pl, bz, dn, er, px, py, pc};
    endfunction

    function automatic logic [23:0] outVec();
        return pack(p1_gnt, p2_gnt, plot, busy, clear_done, coord_err, x, y, colour);
    endfunction

    task automatic checkOutput(input string name, input logic [23:0] act, input logic [23:0] req);
        checks++;
        if (act === req) passed++;
        else $display("[TB] FAIL %s cycle %0d: got %h required %h", name, cyc, act, req);
    endtask

    task automatic reportMissing(input int stamp, input logic [23:0] req);
        checks++;
        $display("[TB] FAIL missing_output cycle %0d: got no output, required %h", stamp, req);
    endtask

    task automatic pushEvent(input int stamp, input bit chk, input logic [23:0] v);
        ev_t e;
        e.stamp = stamp;
        e.chk   = chk;
        e.vec   = v;
        exp_q.push_back(e);
    endtask

    // Reference model: ends cycle k, predicts what the port shows in cycle k+1.
    int clr_start = -1;
    int clr_done  = -1;
    int g1_cyc    = -1;
    int g2_cyc    = -1;
    bit pref_p2   = 1'b0;

    task automatic modelStep(input int k);
        bit         l1, l2, w1, ok;
        logic [7:0] wx;
        logic [6:0] wy;
        logic [2:0] wc;
        if (reset) begin
            while (exp_q.size() > 0 && exp_q[$].stamp > k) void'(exp_q.pop_back());
            clr_start = -1;
            clr_done  = -1;
            g1_cyc    = -1;
            g2_cyc    = -1;
            pref_p2   = 1'b0;
        end else if (clr_done >= 0 && k > clr_start && k < clr_done) begin
            ok = 1'b0;
        end else if (clear_req) begin
            clr_start = k;
            clr_done  = k + 1 + NPIX;
            for (int i = 0; i < NPIX; i++)
                pushEvent(k + 1 + i, 1'b1, pack(1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0,
                          8'(i % (XM + 1)), 7'(i / (XM + 1)), CC));
            pushEvent(clr_done, 1'b1, pack(1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 8'(XM), 7'(YM), CC));
        end else begin
            l1 = p1_req && (g1_cyc != k);
            l2 = p2_req && (g2_cyc != k);
            if (l1 || l2) begin
                w1 = l1 && (!l2 || !pref_p2);
                wx = w1 ? p1_x : p2_x;
                wy = w1 ? p1_y : p2_y;
                wc = w1 ? p1_colour : p2_colour;
                ok = (int'(wx) <= XM) && (int'(wy) <= YM);
                pushEvent(k + 1, ok, pack(w1, !w1, ok, 1'b0, 1'b0, !ok, wx, wy, wc));
                pref_p2 = w1;
                if (w1) g1_cyc = k + 1;
                else    g2_cyc = k + 1;
            end
        end
    endtask

    initial begin : model
        forever begin
            @(posedge clk);
            modelStep(cyc);
            cyc = cyc + 1;
        end
    end

    initial begin : monitor
        ev_t         e;
        logic [23:0] act, req;
        forever begin
            @(posedge clk);
            #1;
            while (exp_q.size() > 0 && exp_q[0].stamp < cyc) begin
                e = exp_q.pop_front();
                reportMissing(e.stamp, e.vec);
            end
            act = outVec();
            if ((p1_gnt | p2_gnt | plot | busy | clear_done | coord_err) === 1'b1) begin
                if (exp_q.size() == 0 || exp_q[0].stamp != cyc) begin
                    checkOutput("unexpected_output", act, 24'h0);
                end else begin
                    e   = exp_q.pop_front();
                    req = e.vec;
                    if (!e.chk) begin
                        act[17:0] = '0;
                        req[17:0] = '0;
                    end
                    checkOutput(e.chk ? "write_event" : "coord_err_event", act, req);
                end
            end
        end
    end

    // Requester behaviour: 0 idle, 1 hold forever, 2 hold until granted once, 3 random traffic.
    task automatic applyStimulus(inout int mode, inout logic req, inout logic [7:0] px,
                                 inout logic [6:0] py, inout logic [2:0] pc, input logic gnt);
        case (mode)
            0: req = 1'b0;
            2: if (req && gnt) begin req = 1'b0; mode = 0; end
            3: begin
                if (req && gnt) req = 1'b0;
                if (!req && $urandom_range(0, 3) != 0) begin
                    req = 1'b1;
                    px  = ($urandom_range(0, 15) == 0) ? 8'($urandom_range(160, 255)) : 8'($urandom_range(0, 159));
                    py  = ($urandom_range(0, 15) == 0) ? 7'($urandom_range(120, 127)) : 7'($urandom_range(0, 119));
                    pc  = 3'($urandom_range(0, 7));
                end
            end
            default: ;
        endcase
    endtask

    task automatic tick();
        @(negedge clk);
        applyStimulus(m1, p1_req, p1_x, p1_y, p1_colour, p1_gnt);
        applyStimulus(m2, p2_req, p2_x, p2_y, p2_colour, p2_gnt);
    endtask

    task automatic setP1(input int mode, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        m1 = mode; p1_req = (mode != 0); p1_x = px; p1_y = py; p1_colour = pc;
    endtask

    task automatic setP2(input int mode, input logic [7:0] px, input logic [6:0] py, input logic [2:0] pc);
        m2 = mode; p2_req = (mode != 0); p2_x = px; p2_y = py; p2_colour = pc;
    endtask

    initial begin : driver
        bit found;
        repeat (3) tick();
        checkOutput("reset_state", outVec(), 24'h0);
        clear_req = 1'b1;
        tick();
        checkOutput("reset_beats_clear", outVec(), 24'h0);
        clear_req = 1'b0;

        $display("[TB] both players held from reset");
        setP1(1, 8'd5, 7'd5, 3'b101);
        setP2(1, 8'd112, 7'd111, 3'b011);
        tick();
        reset = 1'b0;
        repeat (20) tick();
        setP1(0, 8'd0, 7'd0, 3'd0);
        setP2(0, 8'd0, 7'd0, 3'd0);
        repeat (4) tick();

        $display("[TB] out-of-range requests");
        setP1(2, 8'd160, 7'd10, 3'b010);
        repeat (5) tick();
        setP2(2, 8'd10, 7'd120, 3'b100);
        repeat (5) tick();

        $display("[TB] random traffic");
        setP1(3, 8'd1, 7'd2, 3'd3);
        setP2(3, 8'd4, 7'd5, 3'd6);
        repeat (1500) tick();
        setP1(0, 8'd0, 7'd0, 3'd0);
        setP2(0, 8'd0, 7'd0, 3'd0);
        repeat (4) tick();

        $display("[TB] full clear with ignored clear_req pulses");
        clear_req = 1'b1;
        tick();
        for (int i = 0; i < NPIX + 10; i++) begin
            clear_req = (i > 20 && i < NPIX - 100 && $urandom_range(0, 999) == 0);
            tick();
        end
        clear_req = 1'b0;

        $display("[TB] clear racing player requests");
        setP1(2, 8'd20, 7'd20, 3'b110);
        repeat (4) tick();
        clear_req = 1'b1;
        setP1(2, 8'd30, 7'd40, 3'b001);
        setP2(2, 8'd50, 7'd60, 3'b111);
        tick();
        clear_req = 1'b0;
        repeat (NPIX + 10) tick();

        $display("[TB] reset mid-sweep");
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        found = 1'b0;
        for (int i = 0; i < 1000 && !found; i++) begin
            tick();
            if (plot === 1'b1 && busy === 1'b1 && x == 8'd40 && y == 7'd3) found = 1'b1;
        end
        if (!found) begin
            checks++;
            $display("[TB] FAIL sweep_pixel_40_3: got timeout, required pixel within 1000 cycles");
        end
        reset = 1'b1;
        tick();
        checkOutput("abort_outputs", outVec(), 24'h0);
        reset = 1'b0;
        repeat (3) tick();
        clear_req = 1'b1;
        tick();
        clear_req = 1'b0;
        repeat (300) tick();
        reset = 1'b1;
        tick();
        reset = 1'b0;
        repeat (5) tick();

        while (exp_q.size() > 0) begin
            reportMissing(exp_q[0].stamp, exp_q[0].vec);
            void'(exp_q.pop_front());
        end
        $display("%0d/%0d checks passed", passed, checks);
        $finish;
    end

endmodule
